// File: rtl/sbox_pipe_array_if.sv
// Valid/ready beat bus for the S-box pipeline: a beat is LANES bytes plus a mode bit.
// The master drives valid/inv/data; the slave answers with ready.
interface sbox_pipe_array_if #(
    parameter int LANES = 16
) ();
    logic                 valid;
    logic                 ready;
    logic                 inv;
    logic [8*LANES-1:0]   data;

    modport master (output valid, output inv, output data, input ready);
    modport slave  (input valid, input inv, input data, output ready);
endinterface

// File: rtl/sbox_pipe_array.sv
// Pipelined multi-lane AES SubBytes/InvSubBytes engine with per-beat mode select.
// Table lookup feeds stage 1; later stages are an elastic register chain that collapses bubbles.
module sbox_pipe_array #(
    parameter int LANES  = 16,
    parameter int PIPE   = 2,
    parameter bit INV_EN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sbox_pipe_array_if.slave       s,
    sbox_pipe_array_if.master      m,
    output logic [2:0]             occupancy
);

    // Tables are listed in natural order: index 0 is the leftmost byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] ISBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    logic                 in_inv;
    logic [8*LANES-1:0]   lookup;
    logic [PIPE:1]        v;
    logic [PIPE:1]        iv;
    logic [8*LANES-1:0]   d [1:PIPE];
    logic [PIPE:1]        rdy;

    assign in_inv = s.inv & INV_EN;

    always_comb begin
        lookup = '0;
        for (int i = 0; i < LANES; i++) begin
            if (in_inv)
                lookup[8*i +: 8] = ISBOX[s.data[8*i +: 8]];
            else
                lookup[8*i +: 8] = SBOX[s.data[8*i +: 8]];
        end
    end

    // Stage k can load unless every stage from k to the output is full and the sink stalls.
    always_comb begin
        rdy = '0;
        for (int k = 1; k <= PIPE; k++) begin
            rdy[k] = m.ready;
            for (int j = k; j <= PIPE; j++) begin
                if (!v[j])
                    rdy[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v  <= '0;
            iv <= '0;
            for (int k = 1; k <= PIPE; k++)
                d[k] <= '0;
        end else begin
            if (rdy[1]) begin
                v[1] <= s.valid;
                if (s.valid) begin
                    iv[1] <= in_inv;
                    d[1]  <= lookup;
                end
            end
            for (int k = 2; k <= PIPE; k++) begin
                if (rdy[k]) begin
                    v[k] <= v[k-1];
                    if (v[k-1]) begin
                        iv[k] <= iv[k-1];
                        d[k]  <= d[k-1];
                    end
                end
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int k = 1; k <= PIPE; k++)
            occupancy = occupancy + {2'b00, v[k]};
    end

    assign s.ready = rdy[1];
    assign m.valid = v[PIPE];
    assign m.inv   = iv[PIPE];
    assign m.data  = d[PIPE];

endmodule

// File: tb/tb_sbox_pipe_array.sv
// Randomised and directed bench for sbox_pipe_array; the reference S-box is derived from GF(2^8)
// arithmetic and the pipeline is modelled as an ordered queue of beats stamped with their accept cycle.
module tb_sbox_pipe_array;

    localparam int LANES = 16;
    localparam int PIPE  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] occupancy;

    sbox_pipe_array_if #(.LANES(LANES)) s_if ();
    sbox_pipe_array_if #(.LANES(LANES)) m_if ();

    sbox_pipe_array #(.LANES(LANES), .PIPE(PIPE), .INV_EN(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s         (s_if.slave),
        .m         (m_if.master),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         inv;
        logic [127:0] data;
        int           stamp;
    } beat_t;

    beat_t        q[$];
    logic [7:0]   fwdTab [256];
    logic [7:0]   invTab [256];
    int           nChecks = 0;
    int           nFails = 0;
    int           cyc = 0;
    int           emitCnt = 0;
    int           acceptCnt = 0;
    int           firstEmit = -1;
    int           lastEmit = -1;
    logic         expValid;
    logic         expReady;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [7:0] r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [127:0] subst(input logic [127:0] x, input logic useInv);
        logic [127:0] r = '0;
        for (int i = 0; i < LANES; i++)
            r[8*i +: 8] = useInv ? invTab[x[8*i +: 8]] : fwdTab[x[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic iv, input logic [127:0] d, input logic mr);
        @(posedge clk);
        #1;
        s_if.valid = v;
        s_if.inv   = iv;
        s_if.data  = d;
        m_if.ready = mr;
    endtask

    // Reference: beats leave in order; the head is visible once PIPE cycles old,
    // and the input is refused only when PIPE beats are held and the sink stalls.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            q.delete();
            checkOutput("rst_m_valid", {127'd0, m_if.valid}, 128'd0);
            checkOutput("rst_occupancy", {125'd0, occupancy}, 128'd0);
            checkOutput("rst_m_data", m_if.data, 128'd0);
        end else begin
            expValid = (q.size() > 0) && ((cyc - q[0].stamp) >= PIPE);
            expReady = (q.size() < PIPE) || m_if.ready;
            checkOutput("m_valid", {127'd0, m_if.valid}, {127'd0, expValid});
            checkOutput("s_ready", {127'd0, s_if.ready}, {127'd0, expReady});
            checkOutput("occupancy", {125'd0, occupancy}, 128'(q.size()));
            if (expValid) begin
                checkOutput("m_data", m_if.data, subst(q[0].data, q[0].inv));
                checkOutput("m_inv", {127'd0, m_if.inv}, {127'd0, q[0].inv});
            end
            if (expValid && m_if.ready) begin
                void'(q.pop_front());
                emitCnt++;
                if (firstEmit < 0) firstEmit = cyc;
                lastEmit = cyc;
            end
            if (s_if.valid && expReady) begin
                q.push_back('{s_if.inv, s_if.data, cyc});
                acceptCnt++;
            end
        end
    end

    initial begin
        logic [127:0] pat, expPat, rnd, fwdOut;
        logic [7:0]   pv [3];
        logic [7:0]   ev [3];

        s_if.valid = 1'b0;
        s_if.inv   = 1'b0;
        s_if.data  = '0;
        m_if.ready = 1'b1;

        for (int x = 0; x < 256; x++) begin
            logic [7:0] xi = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) xi = 8'(y);
            fwdTab[x] = xi ^ rotl(xi, 1) ^ rotl(xi, 2) ^ rotl(xi, 3) ^ rotl(xi, 4) ^ 8'h63;
            invTab[fwdTab[x]] = 8'(x);
        end
        checkOutput("model_sbox_00", {120'd0, fwdTab[8'h00]}, 128'h63);
        checkOutput("model_sbox_53", {120'd0, fwdTab[8'h53]}, 128'hed);
        checkOutput("model_sbox_ff", {120'd0, fwdTab[8'hff]}, 128'h16);
        checkOutput("model_isbox_63", {120'd0, invTab[8'h63]}, 128'h00);

        // Reset held with a valid beat offered.
        s_if.valid = 1'b1;
        s_if.data  = rand128();
        repeat (4) @(posedge clk);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, '0, 1'b1);

        pv = '{8'h00, 8'h53, 8'hff};
        ev = '{8'h63, 8'hed, 8'h16};
        for (int i = 0; i < LANES; i++) begin
            pat[8*i +: 8]    = pv[i % 3];
            expPat[8*i +: 8] = ev[i % 3];
        end

        applyStimulus(1'b1, 1'b0, pat, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        @(negedge clk) checkOutput("single_early_valid", {127'd0, m_if.valid}, 128'd0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        @(negedge clk);
        checkOutput("single_valid", {127'd0, m_if.valid}, 128'd1);
        checkOutput("single_data", m_if.data, expPat);
        checkOutput("single_inv", {127'd0, m_if.inv}, 128'd0);

        applyStimulus(1'b1, 1'b1, expPat, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        @(negedge clk);
        checkOutput("inverse_data", m_if.data, pat);
        checkOutput("inverse_inv", {127'd0, m_if.inv}, 128'd1);

        rnd = rand128();
        applyStimulus(1'b1, 1'b0, rnd, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        @(negedge clk) fwdOut = m_if.data;
        applyStimulus(1'b1, 1'b1, fwdOut, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        @(negedge clk) checkOutput("roundtrip_data", m_if.data, rnd);

        // 64 back-to-back beats with alternating mode.
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        emitCnt = 0; firstEmit = -1; lastEmit = -1;
        for (int i = 0; i < 64; i++)
            applyStimulus(1'b1, i[0], rand128(), 1'b1);
        repeat (4) applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("stream_count", 128'(emitCnt), 128'd64);
        checkOutput("stream_span", 128'(lastEmit - firstEmit), 128'd63);

        // Five stalled cycles in the middle of a stream.
        emitCnt = 0; acceptCnt = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 1'($urandom_range(0, 1)), rand128(), !(i >= 3 && i < 8));
            if (i == 6) begin
                @(negedge clk);
                checkOutput("stall_occupancy", {125'd0, occupancy}, 128'd2);
                checkOutput("stall_s_ready", {127'd0, s_if.ready}, 128'd0);
            end
        end
        repeat (4) applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("stall_no_loss", 128'(emitCnt), 128'(acceptCnt));

        for (int i = 0; i < 400; i++)
            applyStimulus(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), rand128(),
                          1'($urandom_range(0, 9) < 6));
        repeat (4) applyStimulus(1'b0, 1'b0, '0, 1'b1);

        // Reset while the pipeline is full and stalled.
        repeat (3) applyStimulus(1'b1, 1'b0, rand128(), 1'b0);
        @(negedge clk) checkOutput("prereset_occupancy", {125'd0, occupancy}, 128'd2);
        applyStimulus(1'b1, 1'b1, rand128(), 1'b1);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        rst_n = 1'b1;
        @(negedge clk) checkOutput("postreset_valid", {127'd0, m_if.valid}, 128'd0);
        rnd = rand128();
        applyStimulus(1'b1, 1'b0, rnd, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        @(negedge clk);
        checkOutput("postreset_beat_valid", {127'd0, m_if.valid}, 128'd1);
        checkOutput("postreset_beat_data", m_if.data, subst(rnd, 1'b0));

        repeat (3) applyStimulus(1'b0, 1'b0, '0, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
